// File: rtl/matmul_scheduler.sv
// Issue sequencer for a 4x4 complex matrix product: walks row/column selects row-major and
// tracks in-flight operands so results come out tagged. Optional stall port: MATMUL_SCHED_STALL_EN.
module matmul_scheduler #(
  parameter int unsigned LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef MATMUL_SCHED_STALL_EN
  input  logic       stall,
`endif
  output logic       busy,
  output logic       done,
  output logic       issue_valid,
  output logic [1:0] row_idx,
  output logic [1:0] col_idx,
  output logic       res_valid,
  output logic [1:0] res_row,
  output logic [1:0] res_col
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e       r_state;
  logic         r_busy;
  logic         r_done;
  logic         r_issue;
  logic [1:0]   r_row;
  logic [1:0]   r_col;

  logic [LATENCY-1:0] r_vld;
  logic [1:0]         r_trow [LATENCY];
  logic [1:0]         r_tcol [LATENCY];

  logic       w_stall;
  logic       w_issue;
  logic       w_pending;
  logic [3:0] w_next_idx;

`ifdef MATMUL_SCHED_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_issue    = r_issue & ~w_stall;
  assign w_next_idx = {r_row, r_col} + 4'd1;

  // The last stage is the result currently presented; only earlier stages count as pending.
  always_comb begin
    w_pending = 1'b0;
    for (int unsigned i = 0; i + 1 < LATENCY; i++) begin
      w_pending = w_pending | r_vld[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_issue <= 1'b0;
      r_row   <= 2'd0;
      r_col   <= 2'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StIssue;
            r_busy  <= 1'b1;
            r_issue <= 1'b1;
            r_row   <= 2'd0;
            r_col   <= 2'd0;
          end
        end
        StIssue: begin
          if (!w_stall) begin
            if (r_row == 2'd3 && r_col == 2'd3) begin
              r_state <= StDrain;
              r_issue <= 1'b0;
              r_row   <= 2'd0;
              r_col   <= 2'd0;
            end else begin
              r_row <= w_next_idx[3:2];
              r_col <= w_next_idx[1:0];
            end
          end
        end
        StDrain: begin
          if (!w_pending) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_issue <= 1'b0;
        end
      endcase
    end
  end

  // In-flight tracker keeps shifting during stalls so issued results stay on schedule.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_vld[i]  <= 1'b0;
        r_trow[i] <= 2'd0;
        r_tcol[i] <= 2'd0;
      end
    end else begin
      r_vld[0]  <= w_issue;
      r_trow[0] <= row_idx;
      r_tcol[0] <= col_idx;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_trow[i] <= r_trow[i-1];
        r_tcol[i] <= r_tcol[i-1];
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign issue_valid = w_issue;
  assign row_idx     = w_issue ? r_row : 2'd0;
  assign col_idx     = w_issue ? r_col : 2'd0;
  assign res_valid   = r_vld[LATENCY-1];
  assign res_row     = r_trow[LATENCY-1];
  assign res_col     = r_tcol[LATENCY-1];

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench: three schedulers (LATENCY 1, 4, 16) share stimulus; expectations come from
// the cycle formulas of the product timing.
module tb_matmul_scheduler;

  logic clk;
  logic rst;
  logic start;
`ifdef MATMUL_SCHED_STALL_EN
  logic stall;
`endif

  logic [2:0] busy_w, done_w, iv_w, rv_w;
  logic [1:0] ri_w [3];
  logic [1:0] ci_w [3];
  logic [1:0] rr_w [3];
  logic [1:0] rc_w [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  matmul_scheduler #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .start(start),
`ifdef MATMUL_SCHED_STALL_EN
    .stall(stall),
`endif
    .busy(busy_w[0]), .done(done_w[0]), .issue_valid(iv_w[0]), .row_idx(ri_w[0]),
    .col_idx(ci_w[0]), .res_valid(rv_w[0]), .res_row(rr_w[0]), .res_col(rc_w[0])
  );

  matmul_scheduler #(.LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst), .start(start),
`ifdef MATMUL_SCHED_STALL_EN
    .stall(stall),
`endif
    .busy(busy_w[1]), .done(done_w[1]), .issue_valid(iv_w[1]), .row_idx(ri_w[1]),
    .col_idx(ci_w[1]), .res_valid(rv_w[1]), .res_row(rr_w[1]), .res_col(rc_w[1])
  );

  matmul_scheduler #(.LATENCY(16)) u_lat16 (
    .clk(clk), .rst(rst), .start(start),
`ifdef MATMUL_SCHED_STALL_EN
    .stall(stall),
`endif
    .busy(busy_w[2]), .done(done_w[2]), .issue_valid(iv_w[2]), .row_idx(ri_w[2]),
    .col_idx(ci_w[2]), .res_valid(rv_w[2]), .res_row(rr_w[2]), .res_col(rc_w[2])
  );

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Element index issued in cycle c (start at edge 0), with s stall cycles after index 7.
  function automatic int seq_idx(input int c, input int s);
    if (c < 1) return -1;
    if (c <= 8) return c - 1;
    if (c <= 8 + s) return -1;
    if (c - 1 - s < 16) return c - 1 - s;
    return -1;
  endfunction

  task automatic check_cycle(input int k, input int c, input int s);
    int lat, ei, er;
    string t;
    lat = lat_of(k);
    ei  = seq_idx(c, s);
    er  = seq_idx(c - lat, s);
    t   = $sformatf("L%0d_c%0d", lat, c);
    check({t, "_iv"}, int'(iv_w[k]), (ei >= 0) ? 1 : 0);
    check({t, "_row"}, int'(ri_w[k]), (ei >= 0) ? ei / 4 : 0);
    check({t, "_col"}, int'(ci_w[k]), (ei >= 0) ? ei % 4 : 0);
    check({t, "_rv"}, int'(rv_w[k]), (er >= 0) ? 1 : 0);
    if (er >= 0) begin
      check({t, "_rrow"}, int'(rr_w[k]), er / 4);
      check({t, "_rcol"}, int'(rc_w[k]), er % 4);
    end
    check({t, "_busy"}, int'(busy_w[k]), (c >= 1 && c <= 17 + lat + s) ? 1 : 0);
    check({t, "_done"}, int'(done_w[k]), (c == 17 + lat + s) ? 1 : 0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_L%0d_busy", tag, lat_of(k)), int'(busy_w[k]), 0);
      check($sformatf("%s_L%0d_done", tag, lat_of(k)), int'(done_w[k]), 0);
      check($sformatf("%s_L%0d_iv", tag, lat_of(k)), int'(iv_w[k]), 0);
      check($sformatf("%s_L%0d_rv", tag, lat_of(k)), int'(rv_w[k]), 0);
      check($sformatf("%s_L%0d_idx", tag, lat_of(k)),
            int'({ri_w[k], ci_w[k], rr_w[k], rc_w[k]}), 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One start pulse sampled at edge 0, then per-cycle checks of all three instances.
  task automatic run_product(input int s);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) check_cycle(k, c, s);
      @(posedge clk);
`ifdef MATMUL_SCHED_STALL_EN
      #1 stall = (c + 1 >= 9 && c + 1 <= 8 + s) ? 1'b1 : 1'b0;
`endif
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
`ifdef MATMUL_SCHED_STALL_EN
    stall = 1'b0;
`endif
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single product at each latency.
    run_product(0);

    // Start held high: one product per (18 + LATENCY)-cycle window.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        int lat, per, p;
        lat = lat_of(k);
        per = 18 + lat;
        p   = ((c - 1) % per) + 1;
        check($sformatf("hold_L%0d_c%0d_iv", lat, c), int'(iv_w[k]), (p <= 16) ? 1 : 0);
        if (p <= 16) begin
          check($sformatf("hold_L%0d_c%0d_idx", lat, c), int'({ri_w[k], ci_w[k]}), p - 1);
        end
        check($sformatf("hold_L%0d_c%0d_busy", lat, c), int'(busy_w[k]),
              (p <= 17 + lat) ? 1 : 0);
        check($sformatf("hold_L%0d_c%0d_done", lat, c), int'(done_w[k]),
              (p == 17 + lat) ? 1 : 0);
      end
    end
    start = 1'b0;
    do_reset();

    // Asynchronous reset while (2,1) is being issued.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    check("mid_L4_iv", int'(iv_w[1]), 1);
    check("mid_L4_idx", int'({ri_w[1], ci_w[1]}), 9);
    #1 rst = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #3 rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("post_rst_L%0d_c%0d_rv", lat_of(k), c), int'(rv_w[k]), 0);
        check($sformatf("post_rst_L%0d_c%0d_busy", lat_of(k), c), int'(busy_w[k]), 0);
      end
    end

    // Recovery with a fresh start.
    run_product(0);

`ifdef MATMUL_SCHED_STALL_EN
    // Three-cycle stall right after (1,3) is issued.
    run_product(3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
